// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame parser and its byte-timing helpers.
package uart_frame_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_LEN   = 3'd2;
  localparam logic [2:0] ST_PAY   = 3'd3;
  localparam logic [2:0] ST_CHK   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    S_CMD = ST_CMD,
    S_LEN = ST_LEN,
    S_PAY = ST_PAY,
    S_CHK = ST_CHK
  } frame_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;

  // One UART character is start + 8 data + stop = 10 bit times.
  localparam int CLKS_PER_BIT = 868;
  localparam int BYTE_CLKS    = 10 * CLKS_PER_BIT;

endpackage

// File: rtl/uart_byte_timeout.sv
// Idle-gap timer: counts clocks while enabled, restarts on every byte,
// and strobes o_expire on the last allowed idle clock.
module uart_byte_timeout #(
  parameter int TO_W  = 16,
  parameter int LIMIT = 26040
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  logic [TO_W-1:0] r_cnt;

  // A byte arriving on the terminal cycle suppresses expiry.
  assign o_expire = i_en && !i_clr && (r_cnt == TO_W'(LIMIT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || i_clr || o_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles SYNC/CMD/LEN/payload/CHK frames from received UART bytes,
// validating length, checksum and inter-byte gaps.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN      = 4,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CLKS = 3 * BYTE_CLKS,
  parameter int         TO_W         = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_rx_valid,
  input  logic [7:0]             i_rx_byte,
  output logic                   o_frame_valid,
  output logic [7:0]             o_cmd,
  output logic [4:0]             o_len,
  output logic [8*MAX_LEN-1:0]   o_payload,
  output logic                   o_chk_err,
  output logic                   o_len_err,
  output logic                   o_timeout_err
);

  frame_state_e         r_state, w_state_nxt;
  logic [7:0]           r_sum, w_sum_nxt;
  logic [4:0]           r_idx, w_idx_nxt;
  logic [4:0]           r_len_sh, w_len_sh_nxt;
  logic [7:0]           r_cmd_sh, w_cmd_sh_nxt;
  logic [8*MAX_LEN-1:0] r_shadow, w_shadow_nxt;

  logic [7:0]           r_cmd, w_cmd_nxt;
  logic [4:0]           r_len, w_len_nxt;
  logic [8*MAX_LEN-1:0] r_payload, w_payload_nxt;
  logic                 r_frame_valid, w_frame_valid_nxt;
  logic                 r_chk_err, w_chk_err_nxt;
  logic                 r_len_err, w_len_err_nxt;
  logic                 r_timeout_err, w_timeout_err_nxt;

  logic                 w_to_en;
  logic                 w_expire;

  assign w_to_en = (r_state != IDLE);

  uart_byte_timeout #(
    .TO_W  (TO_W),
    .LIMIT (TIMEOUT_CLKS)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (w_to_en),
    .i_clr    (i_rx_valid),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_sum_nxt         = r_sum;
    w_idx_nxt         = r_idx;
    w_len_sh_nxt      = r_len_sh;
    w_cmd_sh_nxt      = r_cmd_sh;
    w_shadow_nxt      = r_shadow;
    w_cmd_nxt         = r_cmd;
    w_len_nxt         = r_len;
    w_payload_nxt     = r_payload;
    w_frame_valid_nxt = 1'b0;
    w_chk_err_nxt     = 1'b0;
    w_len_err_nxt     = 1'b0;
    w_timeout_err_nxt = 1'b0;

    if (w_expire) begin
      w_timeout_err_nxt = 1'b1;
      w_state_nxt       = IDLE;
    end else if (i_rx_valid) begin
      unique case (r_state)
        IDLE: begin
          if (i_rx_byte == SYNC_BYTE) begin
            w_state_nxt  = S_CMD;
            w_shadow_nxt = '0;
          end
        end
        S_CMD: begin
          w_cmd_sh_nxt = i_rx_byte;
          w_sum_nxt    = i_rx_byte;
          w_state_nxt  = S_LEN;
        end
        S_LEN: begin
          if (i_rx_byte > 8'(MAX_LEN)) begin
            w_len_err_nxt = 1'b1;
            w_state_nxt   = IDLE;
          end else begin
            w_len_sh_nxt = i_rx_byte[4:0];
            w_sum_nxt    = r_sum + i_rx_byte;
            w_idx_nxt    = 5'd0;
            w_state_nxt  = (i_rx_byte == 8'd0) ? S_CHK : S_PAY;
          end
        end
        S_PAY: begin
          w_shadow_nxt[r_idx*8 +: 8] = i_rx_byte;
          w_sum_nxt                  = r_sum + i_rx_byte;
          w_idx_nxt                  = r_idx + 5'd1;
          if ((r_idx + 5'd1) == r_len_sh) begin
            w_state_nxt = S_CHK;
          end
        end
        S_CHK: begin
          if (i_rx_byte == r_sum) begin
            w_frame_valid_nxt = 1'b1;
            w_cmd_nxt         = r_cmd_sh;
            w_len_nxt         = r_len_sh;
            for (int i = 0; i < MAX_LEN; i++) begin
              w_payload_nxt[i*8 +: 8] = (5'(i) < r_len_sh) ? r_shadow[i*8 +: 8] : 8'h00;
            end
          end else begin
            w_chk_err_nxt = 1'b1;
          end
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_sum         <= '0;
      r_idx         <= '0;
      r_len_sh      <= '0;
      r_cmd_sh      <= '0;
      r_shadow      <= '0;
      r_cmd         <= '0;
      r_len         <= '0;
      r_payload     <= '0;
      r_frame_valid <= 1'b0;
      r_chk_err     <= 1'b0;
      r_len_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sum         <= w_sum_nxt;
      r_idx         <= w_idx_nxt;
      r_len_sh      <= w_len_sh_nxt;
      r_cmd_sh      <= w_cmd_sh_nxt;
      r_shadow      <= w_shadow_nxt;
      r_cmd         <= w_cmd_nxt;
      r_len         <= w_len_nxt;
      r_payload     <= w_payload_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_chk_err     <= w_chk_err_nxt;
      r_len_err     <= w_len_err_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign o_frame_valid = r_frame_valid;
  assign o_cmd         = r_cmd;
  assign o_len         = r_len;
  assign o_payload     = r_payload;
  assign o_chk_err     = r_chk_err;
  assign o_len_err     = r_len_err;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: frame vector table plus timeout
// and mid-frame reset sequences.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 4;
  localparam int TO_CLKS = 20;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 rx_valid = 1'b0;
  logic [7:0]           rx_byte = 8'h00;
  logic                 frame_valid;
  logic [7:0]           cmd;
  logic [4:0]           len;
  logic [8*MAX_LEN-1:0] payload;
  logic                 chk_err;
  logic                 len_err;
  logic                 timeout_err;

  uart_frame_parser #(
    .MAX_LEN      (MAX_LEN),
    .SYNC_BYTE    (8'hAA),
    .TIMEOUT_CLKS (TO_CLKS),
    .TO_W         (16)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rx_valid    (rx_valid),
    .i_rx_byte     (rx_byte),
    .o_frame_valid (frame_valid),
    .o_cmd         (cmd),
    .o_len         (len),
    .o_payload     (payload),
    .o_chk_err     (chk_err),
    .o_len_err     (len_err),
    .o_timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b [8];
    int          n;
    logic        fv;
    logic        ce;
    logic        le;
    logic [7:0]  cmd;
    logic [4:0]  len;
    logic [31:0] pay;
  } vec_t;

  vec_t vecs [9];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && ($countones({frame_valid, chk_err, len_err, timeout_err}) > 1)) begin
      n_err++;
      $display("FAIL exclusive pulses: got %b", {frame_valid, chk_err, len_err, timeout_err});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0] = '{b:'{8'hAA,8'h10,8'h02,8'h11,8'h22,8'h45,8'h00,8'h00}, n:6, fv:1'b1, ce:1'b0, le:1'b0, cmd:8'h10, len:5'd2, pay:32'h00002211};
    vecs[1] = '{b:'{8'hAA,8'h10,8'h02,8'h11,8'h22,8'h46,8'h00,8'h00}, n:6, fv:1'b0, ce:1'b1, le:1'b0, cmd:8'h10, len:5'd2, pay:32'h00002211};
    vecs[2] = '{b:'{8'hAA,8'h01,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00}, n:4, fv:1'b1, ce:1'b0, le:1'b0, cmd:8'h01, len:5'd0, pay:32'h00000000};
    vecs[3] = '{b:'{8'hAA,8'h05,8'h05,8'h00,8'h00,8'h00,8'h00,8'h00}, n:3, fv:1'b0, ce:1'b0, le:1'b1, cmd:8'h01, len:5'd0, pay:32'h00000000};
    vecs[4] = '{b:'{8'h11,8'h22,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, n:2, fv:1'b0, ce:1'b0, le:1'b0, cmd:8'h01, len:5'd0, pay:32'h00000000};
    vecs[5] = '{b:'{8'h00,8'hFF,8'hAA,8'h20,8'h01,8'hAA,8'hCB,8'h00}, n:7, fv:1'b1, ce:1'b0, le:1'b0, cmd:8'h20, len:5'd1, pay:32'h000000AA};
    vecs[6] = '{b:'{8'hAA,8'h33,8'h04,8'h01,8'h02,8'h03,8'h04,8'h41}, n:8, fv:1'b1, ce:1'b0, le:1'b0, cmd:8'h33, len:5'd4, pay:32'h04030201};
    vecs[7] = '{b:'{8'hAA,8'h07,8'h01,8'h09,8'h11,8'h00,8'h00,8'h00}, n:5, fv:1'b1, ce:1'b0, le:1'b0, cmd:8'h07, len:5'd1, pay:32'h00000009};
    vecs[8] = '{b:'{8'hAA,8'hFF,8'h02,8'h80,8'h81,8'h02,8'h00,8'h00}, n:6, fv:1'b1, ce:1'b0, le:1'b0, cmd:8'hFF, len:5'd2, pay:32'h00008180};

    repeat (2) @(negedge clk);
    check("reset frame_valid", 32'(frame_valid), 32'd0);
    check("reset cmd",         32'(cmd),         32'd0);
    check("reset len",         32'(len),         32'd0);
    check("reset payload",     32'(payload),     32'd0);
    check("reset chk_err",     32'(chk_err),     32'd0);
    check("reset len_err",     32'(len_err),     32'd0);
    check("reset timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    idle(2);

    for (int v = 0; v < 9; v++) begin
      for (int j = 0; j < vecs[v].n; j++) drive(vecs[v].b[j]);
      check($sformatf("v%0d frame_valid", v), 32'(frame_valid), 32'(vecs[v].fv));
      check($sformatf("v%0d chk_err", v),     32'(chk_err),     32'(vecs[v].ce));
      check($sformatf("v%0d len_err", v),     32'(len_err),     32'(vecs[v].le));
      check($sformatf("v%0d timeout_err", v), 32'(timeout_err), 32'd0);
      check($sformatf("v%0d cmd", v),         32'(cmd),         32'(vecs[v].cmd));
      check($sformatf("v%0d len", v),         32'(len),         32'(vecs[v].len));
      check($sformatf("v%0d payload", v),     payload,          vecs[v].pay);
      idle(1);
      check($sformatf("v%0d pulse width", v),
            32'({frame_valid, chk_err, len_err}), 32'd0);
      idle(2);
    end

    // Inter-byte timeout after CMD
    drive(8'hAA);
    drive(8'h10);
    rx_valid = 1'b0;
    k = 0;
    while (!timeout_err && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("timeout latency", 32'(k), 32'(TO_CLKS));
    @(negedge clk);
    check("timeout pulse width", 32'(timeout_err), 32'd0);
    check("timeout keeps cmd", 32'(cmd), 32'h000000FF);
    idle(2);

    // Byte arriving on the would-be expiry cycle keeps the frame alive
    drive(8'hAA);
    drive(8'h10);
    idle(TO_CLKS - 1);
    drive(8'h01);
    check("expiry race timeout_err", 32'(timeout_err), 32'd0);
    drive(8'h5A);
    drive(8'h6B);
    check("expiry race frame_valid", 32'(frame_valid), 32'd1);
    check("expiry race cmd",         32'(cmd),         32'h00000010);
    check("expiry race len",         32'(len),         32'd1);
    check("expiry race payload",     payload,          32'h0000005A);
    idle(3);

    // Asynchronous reset in the middle of the payload
    drive(8'hAA);
    drive(8'h10);
    drive(8'h02);
    drive(8'h11);
    rx_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst cmd",     32'(cmd),     32'd0);
    check("async rst len",     32'(len),     32'd0);
    check("async rst payload", payload,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    drive(8'h22);
    drive(8'h45);
    check("post rst leftover ignored", 32'({frame_valid, chk_err, len_err}), 32'd0);
    drive(8'hAA);
    drive(8'h10);
    drive(8'h02);
    drive(8'h11);
    drive(8'h22);
    drive(8'h45);
    check("post rst frame_valid", 32'(frame_valid), 32'd1);
    check("post rst cmd",         32'(cmd),         32'h00000010);
    check("post rst len",         32'(len),         32'd2);
    check("post rst payload",     payload,          32'h00002211);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
